mem_access_unit: RTL and testbench

- Parametrised successor to the pipeline's memory-stage access logic.
- Takes one load/store request from the EX/MEM boundary and aligns store data and byte mask onto a DATA_W-wide data bus.
- Runs a handshaked bus transaction, holding the request until the memory's response.
- Returns load data aligned and sign/zero-extended, and stalls the pipeline while the access is outstanding.

---
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store access unit. Accepts one load/store request,
//   aligns store data and byte mask onto a DATA_W-wide bus, runs a
//   handshaked bus transaction (held until mem_resp), and returns the load
//   result aligned and sign/zero-extended. The pipeline is stalled while the
//   access is outstanding.
//
//   Build option: MEM_SPLIT_MISALIGNED_EN
//     defined   - accesses crossing a bus word are split into two beats.
//     undefined - only beat-1 lanes are accessed; high bytes are dropped.
//     In both builds misaligned pulses in DONE for word-crossing accesses.
//
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     req_read/req_write          load / store request (both => store)
//     req_size                    0 byte, 1 half, 2 word, 3 double
//     req_unsigned                zero-extend the load result
//     req_addr, req_wdata         byte address, store data
//     stall                       hold the pipeline
//     load_data, load_valid       extended load result, one-cycle valid
//     misaligned                  one-cycle pulse, access crossed a bus word
//     mem_read/mem_write          bus strobes
//     mem_addr, mem_wdata         lane-aligned address, lane-shifted data
//     mem_wmask                   byte-lane enables
//     mem_rdata, mem_resp         bus read data, one-cycle response
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BYTES  = DATA_W / 8,
    parameter int OFF_W  = $clog2(BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              misaligned,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BYTES-1:0]  mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int MW = 2 * BYTES;

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;
    state_t state, state_nx;

    logic [1:0]        size_q;
    logic              uns_q;
    logic              load_q;
    logic              cross_q;
    logic [OFF_W-1:0]  off_q;
`ifdef MEM_SPLIT_MISALIGNED_EN
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [BYTES-1:0]  mask_hi_q;
`endif

    logic [1:0]        req_size_eff;
    logic [OFF_W-1:0]  req_off;
    logic [MW-1:0]     req_szmask;
    logic [MW-1:0]     req_full_mask;
    logic [DATA_W-1:0] beat1, beat2, raw, load_ext;
    logic [2*DATA_W-1:0] joined;
    logic              sign;
    int unsigned       nb;

    // Request lane math: mask is built 2*BYTES wide so the high half
    // directly gives the second-beat lanes of a word-crossing access.
    always_comb begin
        req_size_eff = req_size;
        if (DATA_W == 32 && req_size == 2'd3) req_size_eff = 2'd2;
        req_off       = req_addr[OFF_W-1:0];
        req_szmask    = MW'((1 << (1 << req_size_eff)) - 1);
        req_full_mask = req_szmask << req_off;
    end

    // Load result: join beats, shift the addressed byte down to lane 0,
    // then replace bytes above the access size with the extension fill.
    always_comb begin
`ifdef MEM_SPLIT_MISALIGNED_EN
        beat1 = (state == BEAT2) ? rdata1_q  : mem_rdata;
        beat2 = (state == BEAT2) ? mem_rdata : '0;
`else
        beat1 = mem_rdata;
        beat2 = '0;
`endif
        joined   = {beat2, beat1} >> {off_q, 3'b000};
        raw      = joined[DATA_W-1:0];
        nb       = 32'd1 << size_q;
        sign     = raw[8*nb-1] & ~uns_q;
        load_ext = raw;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (i >= nb) load_ext[8*i +: 8] = {8{sign}};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (req_read | req_write) state_nx = BEAT1;
            BEAT1: if (mem_resp) begin
`ifdef MEM_SPLIT_MISALIGNED_EN
                state_nx = cross_q ? BEAT2 : DONE;
`else
                state_nx = DONE;
`endif
            end
`ifdef MEM_SPLIT_MISALIGNED_EN
            BEAT2: if (mem_resp) state_nx = DONE;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        stall = ~rst & (((state == IDLE) & (req_read | req_write)) |
                        (state == BEAT1) | (state == BEAT2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            size_q     <= '0;
            uns_q      <= 1'b0;
            load_q     <= 1'b0;
            cross_q    <= 1'b0;
            off_q      <= '0;
`ifdef MEM_SPLIT_MISALIGNED_EN
            wdata_q    <= '0;
            rdata1_q   <= '0;
            mask_hi_q  <= '0;
`endif
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nx;
            load_valid <= 1'b0;
            misaligned <= 1'b0;

            if (state == IDLE && (req_read | req_write)) begin
                size_q    <= req_size_eff;
                uns_q     <= req_unsigned;
                load_q    <= req_read & ~req_write;
                cross_q   <= |req_full_mask[MW-1:BYTES];
                off_q     <= req_off;
`ifdef MEM_SPLIT_MISALIGNED_EN
                wdata_q   <= req_wdata;
                mask_hi_q <= req_full_mask[MW-1:BYTES];
`endif
                mem_read  <= req_read & ~req_write;
                mem_write <= req_write;
                mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                mem_wdata <= req_wdata << {req_off, 3'b000};
                mem_wmask <= req_full_mask[BYTES-1:0];
            end

`ifdef MEM_SPLIT_MISALIGNED_EN
            if (state == BEAT1 && mem_resp) rdata1_q <= mem_rdata;
            if (state == BEAT1 && state_nx == BEAT2) begin
                mem_addr  <= mem_addr + ADDR_W'(BYTES);
                mem_wmask <= mask_hi_q;
                mem_wdata <= wdata_q >> (8 * (BYTES - int'(off_q)));
            end
`endif

            // Last response of the access: drop strobes, publish result.
            if (state_nx == DONE) begin
                mem_read   <= 1'b0;
                mem_write  <= 1'b0;
                mem_wmask  <= '0;
                load_valid <= load_q;
                misaligned <= cross_q;
                if (load_q) load_data <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic clk;
    logic rst;

    // 32-bit instance signals
    logic        r32_read, r32_write, r32_uns;
    logic [1:0]  r32_size;
    logic [31:0] r32_addr, r32_wdata;
    logic        s32_stall, ld32_valid, mis32, mr32, mw32, resp32;
    logic [31:0] ld32_data, ma32, mwd32, rd32;
    logic [3:0]  mwm32;

    // 64-bit instance signals
    logic        r64_read, r64_write, r64_uns;
    logic [1:0]  r64_size;
    logic [31:0] r64_addr;
    logic [63:0] r64_wdata;
    logic        s64_stall, ld64_valid, mis64, mr64, mw64, resp64;
    logic [63:0] ld64_data, mwd64, rd64;
    logic [31:0] ma64;
    logic [7:0]  mwm64;

    int checks = 0;
    int errors = 0;

    // observations from the last transaction
    int          nbeats, stall_cnt, lv_cnt, mis_cnt;
    logic [63:0] ld_obs;
    logic [31:0] b_addr  [2];
    logic [7:0]  b_mask  [2];
    logic [63:0] b_wdata [2];
    logic        b_rd    [2];
    logic        b_wr    [2];

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut32 (
        .clk(clk), .rst(rst),
        .req_read(r32_read), .req_write(r32_write), .req_size(r32_size),
        .req_unsigned(r32_uns), .req_addr(r32_addr), .req_wdata(r32_wdata),
        .stall(s32_stall), .load_data(ld32_data), .load_valid(ld32_valid),
        .misaligned(mis32), .mem_read(mr32), .mem_write(mw32),
        .mem_addr(ma32), .mem_wdata(mwd32), .mem_wmask(mwm32),
        .mem_rdata(rd32), .mem_resp(resp32)
    );

    mem_access_unit #(.ADDR_W(32), .DATA_W(64)) dut64 (
        .clk(clk), .rst(rst),
        .req_read(r64_read), .req_write(r64_write), .req_size(r64_size),
        .req_unsigned(r64_uns), .req_addr(r64_addr), .req_wdata(r64_wdata),
        .stall(s64_stall), .load_data(ld64_data), .load_valid(ld64_valid),
        .misaligned(mis64), .mem_read(mr64), .mem_write(mw64),
        .mem_addr(ma64), .mem_wdata(mwd64), .mem_wmask(mwm64),
        .mem_rdata(rd64), .mem_resp(resp64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request on the 32-bit unit and plays the bus responder for
    // a fixed window, recording what was seen on each beat.
    task automatic run32(input logic is_rd, input logic is_wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input int waits, input logic [31:0] rdat1, input logic [31:0] rdat2);
        int wl;
        wl = waits; nbeats = 0; stall_cnt = 0; lv_cnt = 0; mis_cnt = 0; ld_obs = '0;
        r32_read = is_rd; r32_write = is_wr; r32_size = sz; r32_uns = uns;
        r32_addr = addr; r32_wdata = wd;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc == 1) begin r32_read = 1'b0; r32_write = 1'b0; end
            #1;
            if (s32_stall) stall_cnt++;
            if (ld32_valid) begin lv_cnt++; ld_obs = 64'(ld32_data); end
            if (mis32) mis_cnt++;
            resp32 = 1'b0;
            if (mr32 | mw32) begin
                if (wl > 0) wl--;
                else begin
                    if (nbeats < 2) begin
                        b_addr[nbeats] = ma32; b_mask[nbeats] = 8'(mwm32);
                        b_wdata[nbeats] = 64'(mwd32); b_rd[nbeats] = mr32; b_wr[nbeats] = mw32;
                    end
                    rd32 = (nbeats == 0) ? rdat1 : rdat2;
                    resp32 = 1'b1; nbeats++; wl = waits;
                end
            end
            @(negedge clk);
        end
        resp32 = 1'b0;
    endtask

    task automatic run64(input logic is_rd, input logic is_wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [63:0] rdat1);
        nbeats = 0; stall_cnt = 0; lv_cnt = 0; mis_cnt = 0; ld_obs = '0;
        r64_read = is_rd; r64_write = is_wr; r64_size = sz; r64_uns = uns;
        r64_addr = addr; r64_wdata = wd;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc == 1) begin r64_read = 1'b0; r64_write = 1'b0; end
            #1;
            if (s64_stall) stall_cnt++;
            if (ld64_valid) begin lv_cnt++; ld_obs = ld64_data; end
            if (mis64) mis_cnt++;
            resp64 = 1'b0;
            if (mr64 | mw64) begin
                if (nbeats < 2) begin
                    b_addr[nbeats] = ma64; b_mask[nbeats] = mwm64;
                    b_wdata[nbeats] = mwd64; b_rd[nbeats] = mr64; b_wr[nbeats] = mw64;
                end
                rd64 = rdat1; resp64 = 1'b1; nbeats++;
            end
            @(negedge clk);
        end
        resp64 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        r32_read = 1'b1; r64_write = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (s32_stall !== 1'b0) begin errors++; $display("FAIL rst_stall32: got %b want 0", s32_stall); end
        checks++; if (s64_stall !== 1'b0) begin errors++; $display("FAIL rst_stall64: got %b want 0", s64_stall); end
        checks++; if ({mr32, mw32, ld32_valid, mis32} !== 4'b0) begin errors++; $display("FAIL rst_flags32: got %b want 0000", {mr32, mw32, ld32_valid, mis32}); end
        checks++; if ({ma32, mwd32, mwm32, ld32_data} !== 100'b0) begin errors++; $display("FAIL rst_data32: got %h %h %h %h want 0", ma32, mwd32, mwm32, ld32_data); end
        checks++; if ({mr64, mw64, ld64_valid, mis64, mwm64, ma64, mwd64, ld64_data} !== '0) begin errors++; $display("FAIL rst_all64: got nonzero output %h %h %h %h", ma64, mwm64, mwd64, ld64_data); end
        r32_read = 1'b0; r64_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store;
        // SW with two wait cycles
        run32(1'b0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 2, 32'h0, 32'h0);
        checks++; if (nbeats !== 1) begin errors++; $display("FAIL sw_beats: got %0d want 1", nbeats); end
        checks++; if ({b_addr[0], b_mask[0], b_wdata[0][31:0]} !== {32'h1000, 8'h0F, 32'hDEADBEEF}) begin errors++; $display("FAIL sw_bus: got %h %h %h want 00001000 0f deadbeef", b_addr[0], b_mask[0], b_wdata[0][31:0]); end
        checks++; if ({b_wr[0], b_rd[0]} !== 2'b10) begin errors++; $display("FAIL sw_strobes: got %b want 10", {b_wr[0], b_rd[0]}); end
        checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL sw_stall: got %0d want 4", stall_cnt); end
        checks++; if (lv_cnt !== 0 || mis_cnt !== 0) begin errors++; $display("FAIL sw_pulses: got lv %0d mis %0d want 0 0", lv_cnt, mis_cnt); end
        // SB to top lane
        run32(1'b0, 1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000AB, 0, 32'h0, 32'h0);
        checks++; if ({b_addr[0], b_mask[0], b_wdata[0][31:0]} !== {32'h1000, 8'h08, 32'hAB000000}) begin errors++; $display("FAIL sb_bus: got %h %h %h want 00001000 08 ab000000", b_addr[0], b_mask[0], b_wdata[0][31:0]); end
        checks++; if (stall_cnt !== 2) begin errors++; $display("FAIL sb_stall: got %0d want 2", stall_cnt); end
        // read and write together: store only
        run32(1'b1, 1'b1, 2'd2, 1'b0, 32'h0500, 32'h12345678, 0, 32'hFFFFFFFF, 32'h0);
        checks++; if ({nbeats == 1, b_wr[0], b_rd[0], lv_cnt == 0} !== 4'b1101) begin errors++; $display("FAIL rw_both: got beats %0d wr %b rd %b lv %0d want 1 1 0 0", nbeats, b_wr[0], b_rd[0], lv_cnt); end
    endtask

    task automatic test_load_ext;
        run32(1'b1, 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 0, 32'h80120000, 32'h0);
        checks++; if (ld_obs[31:0] !== 32'hFFFF8012) begin errors++; $display("FAIL lh_data: got %h want ffff8012", ld_obs[31:0]); end
        checks++; if (lv_cnt !== 1) begin errors++; $display("FAIL lh_valid: got %0d want 1", lv_cnt); end
        checks++; if ({b_addr[0], b_mask[0], b_rd[0]} !== {32'h2000, 8'h0C, 1'b1}) begin errors++; $display("FAIL lh_bus: got %h %h %b want 00002000 0c 1", b_addr[0], b_mask[0], b_rd[0]); end
        run32(1'b1, 1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 1, 32'h80120000, 32'h0);
        checks++; if (ld_obs[31:0] !== 32'h00008012) begin errors++; $display("FAIL lhu_data: got %h want 00008012", ld_obs[31:0]); end
        // size 3 on a 32-bit bus acts as a word: single beat, no crossing
        run32(1'b1, 1'b0, 2'd3, 1'b0, 32'h0100, 32'h0, 0, 32'h80000001, 32'h0);
        checks++; if ({nbeats == 1, mis_cnt == 0, b_mask[0]} !== {2'b11, 8'h0F}) begin errors++; $display("FAIL sz3_clamp: got beats %0d mis %0d mask %h want 1 0 0f", nbeats, mis_cnt, b_mask[0]); end
        checks++; if (ld_obs[31:0] !== 32'h80000001) begin errors++; $display("FAIL sz3_data: got %h want 80000001", ld_obs[31:0]); end
    endtask

    task automatic test_misaligned;
        run32(1'b1, 1'b0, 2'd2, 1'b0, 32'h3002, 32'h0, 0, 32'h44331122, 32'h99886655);
        checks++; if (mis_cnt !== 1) begin errors++; $display("FAIL lw_mis_pulse: got %0d want 1", mis_cnt); end
`ifdef MEM_SPLIT_MISALIGNED_EN
        checks++; if (nbeats !== 2) begin errors++; $display("FAIL lw_mis_beats: got %0d want 2", nbeats); end
        checks++; if ({b_addr[0], b_addr[1], b_mask[0], b_mask[1]} !== {32'h3000, 32'h3004, 8'h0C, 8'h03}) begin errors++; $display("FAIL lw_mis_bus: got %h %h %h %h want 00003000 00003004 0c 03", b_addr[0], b_addr[1], b_mask[0], b_mask[1]); end
        checks++; if (ld_obs[31:0] !== 32'h66554433) begin errors++; $display("FAIL lw_mis_data: got %h want 66554433", ld_obs[31:0]); end
        checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL lw_mis_stall: got %0d want 3", stall_cnt); end
`else
        checks++; if (nbeats !== 1) begin errors++; $display("FAIL lw_mis_beats: got %0d want 1", nbeats); end
        checks++; if ({b_addr[0], b_mask[0]} !== {32'h3000, 8'h0C}) begin errors++; $display("FAIL lw_mis_bus: got %h %h want 00003000 0c", b_addr[0], b_mask[0]); end
        checks++; if (ld_obs[31:0] !== 32'h00004433) begin errors++; $display("FAIL lw_mis_data: got %h want 00004433", ld_obs[31:0]); end
`endif
        // SH at the top of the address space: second beat wraps to 0
        run32(1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF, 0, 32'h0, 32'h0);
        checks++; if ({b_addr[0], b_mask[0], b_wdata[0][31:0]} !== {32'hFFFFFFFC, 8'h08, 32'hEF000000}) begin errors++; $display("FAIL sh_wrap_b1: got %h %h %h want fffffffc 08 ef000000", b_addr[0], b_mask[0], b_wdata[0][31:0]); end
`ifdef MEM_SPLIT_MISALIGNED_EN
        checks++; if ({nbeats == 2, b_addr[1], b_mask[1], b_wdata[1][31:0]} !== {1'b1, 32'h0, 8'h01, 32'h000000BE}) begin errors++; $display("FAIL sh_wrap_b2: got beats %0d %h %h %h want 2 00000000 01 000000be", nbeats, b_addr[1], b_mask[1], b_wdata[1][31:0]); end
`else
        checks++; if (nbeats !== 1 || mis_cnt !== 1) begin errors++; $display("FAIL sh_wrap_single: got beats %0d mis %0d want 1 1", nbeats, mis_cnt); end
`endif
    endtask

    task automatic test_wide64;
        run64(1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 64'h0123456789ABCDEF, 64'h0);
        checks++; if ({nbeats == 1, b_addr[0], b_mask[0], b_wdata[0]} !== {1'b1, 32'h10, 8'hFF, 64'h0123456789ABCDEF}) begin errors++; $display("FAIL sd64_bus: got beats %0d %h %h %h want 1 00000010 ff 0123456789abcdef", nbeats, b_addr[0], b_mask[0], b_wdata[0]); end
        run64(1'b1, 1'b0, 2'd0, 1'b0, 32'h17, 64'h0, 64'h7F11223344556680);
        checks++; if (ld_obs !== 64'h000000000000007F) begin errors++; $display("FAIL lb64_data: got %h want 000000000000007f", ld_obs); end
        checks++; if ({b_addr[0], b_mask[0], lv_cnt == 1} !== {32'h10, 8'h80, 1'b1}) begin errors++; $display("FAIL lb64_bus: got %h %h lv %0d want 00000010 80 1", b_addr[0], b_mask[0], lv_cnt); end
        run64(1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 64'h0, 64'h89ABCDEF00000000);
        checks++; if (ld_obs !== 64'hFFFFFFFF89ABCDEF) begin errors++; $display("FAIL lw64_data: got %h want ffffffff89abcdef", ld_obs); end
        run64(1'b1, 1'b0, 2'd2, 1'b1, 32'h4, 64'h0, 64'h89ABCDEF00000000);
        checks++; if (ld_obs !== 64'h0000000089ABCDEF) begin errors++; $display("FAIL lwu64_data: got %h want 0000000089abcdef", ld_obs); end
    endtask

    task automatic test_reset_abort;
        r32_read = 1'b1; r32_write = 1'b0; r32_size = 2'd2; r32_uns = 1'b0; r32_addr = 32'h40;
        @(negedge clk);
        r32_read = 1'b0;
        #1;
        checks++; if (mr32 !== 1'b1) begin errors++; $display("FAIL abort_beat1: got read %b want 1", mr32); end
        rst = 1'b1;
        #1;
        checks++; if (s32_stall !== 1'b0) begin errors++; $display("FAIL abort_stall_rst: got %b want 0", s32_stall); end
        @(negedge clk);
        rst = 1'b0; resp32 = 1'b1; rd32 = 32'hCAFEF00D;
        #1;
        checks++; if ({mr32, mw32, s32_stall} !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b want 000", {mr32, mw32, s32_stall}); end
        @(negedge clk);
        resp32 = 1'b0;
        #1;
        checks++; if ({ld32_valid, mr32, s32_stall} !== 3'b000) begin errors++; $display("FAIL abort_late_resp: got %b want 000", {ld32_valid, mr32, s32_stall}); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        r32_read = 1'b0; r32_write = 1'b0; r32_size = '0; r32_uns = 1'b0; r32_addr = '0; r32_wdata = '0;
        rd32 = '0; resp32 = 1'b0;
        r64_read = 1'b0; r64_write = 1'b0; r64_size = '0; r64_uns = 1'b0; r64_addr = '0; r64_wdata = '0;
        rd64 = '0; resp64 = 1'b0;
        @(negedge clk);
        test_reset();
        test_store();
        test_load_ext();
        test_misaligned();
        test_wide64();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
